// File: rtl/dac_spi_loader.sv
// dac_spi_loader: latches NI DAC write strobes and sends each pending value as a 16-bit SPI frame followed by an LDAC pulse
module dac_spi_loader #(
    parameter int CLK_DIV     = 4,
    parameter int LDAC_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       set_hvdac,
    input  logic       set_biasdac,
    input  logic       set_thrshdac,
    output logic       dac_sclk,
    output logic       dac_sdi,
    output logic       dac_cs_n,
    output logic       dac_ldac_n,
    output logic       busy,
    output logic [2:0] pending
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] SHIFT   = 3'd2;
    localparam logic [2:0] CS_HOLD = 3'd3;
    localparam logic [2:0] LDAC    = 3'd4;
    localparam logic [2:0] GAP     = 3'd5;
    localparam int MAXC = CLK_DIV > LDAC_CYCLES ? CLK_DIV : LDAC_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LDAC_LAST = CW'(LDAC_CYCLES - 1);

    logic [2:0]      strobe, strobe_q, ev, clr, pending_q, pending_d, state_q, state_d;
    logic [2:0][7:0] pend_data_q, pend_data_d;
    logic [15:0]     shreg_q, shreg_d;
    logic [3:0]      bit_q, bit_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      sel;
    logic [7:0]      sel_data;
    logic            cnt_done, sclk_q, sclk_d, sdi_q, sdi_d, cs_n_q, cs_n_d, ldac_n_q, ldac_n_d, busy_q;

    always_comb begin
        strobe = {set_thrshdac, set_biasdac, set_hvdac};
        ev = strobe & ~strobe_q;
        sel = pending_q[0] ? 2'd0 : pending_q[1] ? 2'd1 : 2'd2;
        sel_data = pending_q[0] ? pend_data_q[0] : pending_q[1] ? pend_data_q[1] : pend_data_q[2];
        cnt_done = cnt_q == DIV_LAST;
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d = bit_q;
        cnt_d = cnt_q + 1'b1;
        sclk_d = sclk_q;
        sdi_d = sdi_q;
        cs_n_d = cs_n_q;
        ldac_n_d = ldac_n_q;
        clr = 3'b000;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pending_q != 3'b000) begin
                    state_d = LOAD;
                    clr = 3'b001 << sel;
                    shreg_d = {2'b00, sel, sel_data, 4'b0000};
                    sdi_d = shreg_d[15];
                    cs_n_d = 1'b0;
                end
            end
            LOAD: begin
                state_d = SHIFT;
                cnt_d = '0;
                bit_d = '0;
                sclk_d = 1'b0;
            end
            SHIFT: begin
                if (cnt_done) begin
                    cnt_d = '0;
                    sclk_d = ~sclk_q;
                    if (sclk_q && bit_q == 4'd15) begin
                        state_d = CS_HOLD;
                        sdi_d = 1'b0;
                    end else if (sclk_q) begin
                        bit_d = bit_q + 4'd1;
                        shreg_d = shreg_q << 1;
                        sdi_d = shreg_q[14];
                    end
                end
            end
            CS_HOLD: begin
                if (cnt_done) begin
                    cnt_d = '0;
                    cs_n_d = 1'b1;
                    ldac_n_d = 1'b0;
                    state_d = LDAC;
                end
            end
            LDAC: begin
                if (cnt_q == LDAC_LAST) begin
                    cnt_d = '0;
                    ldac_n_d = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_done) begin
                    cnt_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // a same-cycle event re-arms the channel being dispatched, so its new byte gets its own frame
        pending_d = (pending_q & ~clr) | ev;
        for (int i = 0; i < 3; i++) pend_data_d[i] = ev[i] ? din : pend_data_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_q <= '0;
            pending_q <= '0;
            pend_data_q <= '0;
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q <= '0;
            cnt_q <= '0;
            sclk_q <= 1'b0;
            sdi_q <= 1'b0;
            cs_n_q <= 1'b1;
            ldac_n_q <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            strobe_q <= strobe;
            pending_q <= pending_d;
            pend_data_q <= pend_data_d;
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q <= bit_d;
            cnt_q <= cnt_d;
            sclk_q <= sclk_d;
            sdi_q <= sdi_d;
            cs_n_q <= cs_n_d;
            ldac_n_q <= ldac_n_d;
            busy_q <= state_d != IDLE;
        end
    end

    assign dac_sclk = sclk_q;
    assign dac_sdi = sdi_q;
    assign dac_cs_n = cs_n_q;
    assign dac_ldac_n = ldac_n_q;
    assign busy = busy_q;
    assign pending = pending_q;
endmodule

// File: tb/tb_dac_spi_loader.sv
// tb_dac_spi_loader: directed stimulus with per-instance frame scoreboards for default and minimum timing parameters
module tb_dac_spi_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_v, hv, bi, th, sclk, sdi, csn, ldacn, busy;
    logic [7:0]  din0, din1;
    logic [2:0]  pend0, pend1;
    logic [15:0] q0[$], q1[$];
    int total = 0, bad = 0;

    dac_spi_loader dut0 (
        .clk(clk), .rst(rst_v[0]), .din(din0),
        .set_hvdac(hv[0]), .set_biasdac(bi[0]), .set_thrshdac(th[0]),
        .dac_sclk(sclk[0]), .dac_sdi(sdi[0]), .dac_cs_n(csn[0]), .dac_ldac_n(ldacn[0]),
        .busy(busy[0]), .pending(pend0)
    );

    dac_spi_loader #(.CLK_DIV(1), .LDAC_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst_v[1]), .din(din1),
        .set_hvdac(hv[1]), .set_biasdac(bi[1]), .set_thrshdac(th[1]),
        .dac_sclk(sclk[1]), .dac_sdi(sdi[1]), .dac_cs_n(csn[1]), .dac_ldac_n(ldacn[1]),
        .busy(busy[1]), .pending(pend1)
    );

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int k, input logic [2:0] m, input logic [7:0] d, input int n);
        if (k == 0) din0 = d; else din1 = d;
        {th[k], bi[k], hv[k]} = m;
        repeat (n) tick();
        {th[k], bi[k], hv[k]} = 3'b000;
    endtask

    task automatic wait_idle(input int k, input string n);
        int c = 0;
        while (busy[k] && c < 3000) begin
            tick();
            c++;
        end
        chk(n, int'(busy[k]), 0);
    endtask

    task automatic wait_drain(input int k, input string n);
        int c = 0;
        while ((busy[k] || (k == 0 ? pend0 : pend1) != 3'b000) && c < 3000) begin
            tick();
            c++;
        end
        chk(n, int'(busy[k]) + int'(k == 0 ? pend0 : pend1), 0);
    endtask

    // watches one DUT's pins, rebuilds frames from sclk rising edges and checks them against its queue
    task automatic mon(input int k, input int div, input int ld, input int bz);
        logic ps, pc, pl, pb, ab;
        int nb, lc, bc, last, cyc;
        logic [15:0] sh, e;
        ps = 1'b0; pc = 1'b1; pl = 1'b1; pb = 1'b0; ab = 1'b1;
        nb = 0; lc = 0; bc = 0; last = 0; cyc = 0; sh = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_v[k]) begin
                ab = 1'b1;
                nb = 0;
            end else if (busy[k] && !pb) begin
                ab = 1'b0;
                bc = 0;
            end
            if (busy[k]) bc++;
            if (!busy[k] && pb && !ab) chk("busy_len", bc, bz);
            if (!csn[k] && sclk[k] && !ps) begin
                if (nb > 0) chk("sclk_period", cyc - last, 2 * div);
                last = cyc;
                sh = {sh[14:0], sdi[k]};
                nb++;
            end
            if (csn[k] && !pc && !ab) begin
                if (k == 0) e = q0.size() > 0 ? q0.pop_front() : 16'hFFFF;
                else e = q1.size() > 0 ? q1.pop_front() : 16'hFFFF;
                chk("frame_bits", nb, 16);
                chk("frame", int'(sh), int'(e));
                nb = 0;
            end
            if (csn[k]) chk("sdi_idle", int'(sdi[k]), 0);
            if (!ldacn[k]) chk("ldac_cs", int'(csn[k]), 1);
            if (ldacn[k] && !pl && !ab) chk("ldac_len", lc, ld);
            lc = ldacn[k] ? 0 : lc + 1;
            ps = sclk[k]; pc = csn[k]; pl = ldacn[k]; pb = busy[k];
        end
    endtask

    initial fork
        mon(0, 4, 2, 139);
        mon(1, 1, 1, 36);
    join_none

    initial begin
        int r, c;
        logic p;
        rst_v = 2'b11; hv = '0; bi = '0; th = '0; din0 = '0; din1 = '0;
        repeat (3) tick();
        chk("rst_csn", int'(csn[0]), 1);
        chk("rst_sclk", int'(sclk[0]), 0);
        chk("rst_ldac", int'(ldacn[0]), 1);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_pend", int'(pend0), 0);
        chk("rst_sdi", int'(sdi[0]), 0);
        rst_v = 2'b00;
        tick();
        // single bias write held 3 cycles
        q0.push_back(16'h1A50);
        bi[0] = 1'b1; din0 = 8'hA5;
        tick();
        chk("t1_pend", int'(pend0), 3'b010);
        chk("t1_csn_e0", int'(csn[0]), 1);
        tick();
        chk("t1_csn_e1", int'(csn[0]), 0);
        tick();
        bi[0] = 1'b0;
        chk("t1_single_event", int'(pend0), 0);
        wait_drain(0, "t1_drain");
        // simultaneous events on all channels share the din byte
        q0.push_back(16'h0120); q0.push_back(16'h1120); q0.push_back(16'h2120);
        write(0, 3'b111, 8'h12, 1);
        chk("t2_pend111", int'(pend0), 3'b111);
        tick();
        chk("t2_pend110", int'(pend0), 3'b110);
        wait_idle(0, "t2_idle_a");
        tick();
        chk("t2_pend100", int'(pend0), 3'b100);
        wait_idle(0, "t2_idle_b");
        tick();
        chk("t2_pend000", int'(pend0), 3'b000);
        wait_drain(0, "t2_drain");
        // coalescing of two thrsh writes during a hv frame
        q0.push_back(16'h0010); q0.push_back(16'h2220);
        write(0, 3'b001, 8'h01, 1);
        repeat (10) tick();
        write(0, 3'b100, 8'h11, 1);
        tick();
        write(0, 3'b100, 8'h22, 1);
        chk("t3_pend", int'(pend0), 3'b100);
        wait_drain(0, "t3_drain");
        // hv event lands on the dispatch cycle of a pending hv value
        q0.push_back(16'h1010); q0.push_back(16'h07F0); q0.push_back(16'h0800);
        write(0, 3'b010, 8'h01, 1);
        repeat (10) tick();
        write(0, 3'b001, 8'h7F, 1);
        wait_idle(0, "t4_idle");
        chk("t4_pend_before", int'(pend0), 3'b001);
        hv[0] = 1'b1; din0 = 8'h80;
        tick();
        hv[0] = 1'b0;
        chk("t4_pend_race", int'(pend0), 3'b001);
        chk("t4_csn", int'(csn[0]), 0);
        wait_drain(0, "t4_drain");
        // reset after the 5th sclk rise aborts the frame and drops pending bias
        write(0, 3'b011, 8'h3C, 1);
        r = 0; c = 0; p = 1'b0;
        while (r < 5 && c < 500) begin
            tick();
            c++;
            if (sclk[0] && !p) r++;
            p = sclk[0];
        end
        chk("t5_rises", r, 5);
        rst_v[0] = 1'b1;
        tick();
        chk("t5_csn", int'(csn[0]), 1);
        chk("t5_sclk", int'(sclk[0]), 0);
        chk("t5_ldac", int'(ldacn[0]), 1);
        chk("t5_busy", int'(busy[0]), 0);
        chk("t5_pend", int'(pend0), 0);
        chk("t5_sdi", int'(sdi[0]), 0);
        rst_v[0] = 1'b0;
        c = 0;
        repeat (300) begin
            tick();
            if (busy[0] || !csn[0]) c++;
        end
        chk("t5_no_frame", c, 0);
        // minimum timing parameters
        q1.push_back(16'h1A50);
        write(1, 3'b010, 8'hA5, 3);
        wait_drain(1, "t6_drain_a");
        q1.push_back(16'h0C30);
        write(1, 3'b001, 8'hC3, 1);
        wait_drain(1, "t6_drain_b");
        repeat (4) tick();
        chk("q0_left", q0.size(), 0);
        chk("q1_left", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
